// File: rtl/simple_spi_pkg.sv
// rtl/simple_spi_pkg.sv - shared state type, synchronizer depth and SPI mode-0 edge constants
package simple_spi_pkg;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    localparam int SYNC_STAGES = 2;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;
    // Modes 0 and 3 sample on the SCK rising edge and shift on the falling edge.
    localparam logic SAMPLE_ON_RISE = (SPI_CPOL == SPI_CPHA);

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with optional single-cycle rise/fall detection
module spi_sync_edge
    import simple_spi_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0,
    parameter bit   EDGE_EN   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic prev_q, prev_d;

            always_comb begin
                prev_d = dout;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_q <= RESET_VAL;
                end else begin
                    prev_q <= prev_d;
                end
            end

            assign rise = dout & ~prev_q;
            assign fall = ~dout & prev_q;
        end else begin : g_no_edge
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/simple_spi_slave.sv
// rtl/simple_spi_slave.sv - mode-0 SPI responder with one-entry tx holding register
// Optional tx_underrun/rx_abort pulses when SIMPLE_SPI_SLAVE_STATUS_EN is defined.
module simple_spi_slave
    import simple_spi_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]  DEFAULT_TX = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  spi_clk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso
`ifdef SIMPLE_SPI_SLAVE_STATUS_EN
    ,
    output logic                  tx_underrun,
    output logic                  rx_abort
`endif
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_sync;
    logic sck_level_unused, cs_level_unused, mosi_rise_unused, mosi_fall_unused;
    logic sample_edge, shift_edge;

    spi_sync_edge #(.RESET_VAL(SPI_CPOL), .EDGE_EN(1'b1)) u_sck_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi_clk),
        .dout (sck_level_unused),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1), .EDGE_EN(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi_cs_n),
        .dout (cs_level_unused),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0), .EDGE_EN(1'b0)) u_mosi_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi_mosi),
        .dout (mosi_sync),
        .rise (mosi_rise_unused),
        .fall (mosi_fall_unused)
    );

    assign sample_edge = SAMPLE_ON_RISE ? sck_rise : sck_fall;
    assign shift_edge  = SAMPLE_ON_RISE ? sck_fall : sck_rise;

    state_t                state_q, state_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  new_word_q, new_word_d;
    logic                  rx_done_q, rx_done_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  miso_q, miso_d;
    logic                  word_load;
    logic [DATA_WIDTH-1:0] load_word;
`ifdef SIMPLE_SPI_SLAVE_STATUS_EN
    logic                  underrun_q, underrun_d;
    logic                  abort_q, abort_d;
`endif

    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        bit_cnt_d   = bit_cnt_q;
        new_word_d  = new_word_q;
        rx_done_d   = 1'b0;
        rx_valid_d  = rx_done_q;
        miso_d      = miso_q;
        word_load   = 1'b0;
        load_word   = DEFAULT_TX;
`ifdef SIMPLE_SPI_SLAVE_STATUS_EN
        underrun_d  = 1'b0;
        abort_d     = 1'b0;
`endif

        // rx_shift already holds the finished word one cycle after the last sample.
        if (rx_done_q) begin
            rx_data_d = rx_shift_q;
        end

        if (tx_valid && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_d      = tx_data;
        end

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    word_load = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d    = IDLE;
                    miso_d     = 1'b0;
                    bit_cnt_d  = '0;
                    new_word_d = 1'b0;
`ifdef SIMPLE_SPI_SLAVE_STATUS_EN
                    abort_d    = (bit_cnt_q != '0);
`endif
                end else if (sample_edge) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d  = '0;
                        new_word_d = 1'b1;
                        rx_done_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (shift_edge) begin
                    if (new_word_q) begin
                        word_load  = 1'b1;
                        new_word_d = 1'b0;
                    end else begin
                        miso_d     = tx_shift_q[DATA_WIDTH-1];
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Only a full register is consumed, so a same-cycle write to an empty one survives.
        if (word_load) begin
            if (hold_full_q) begin
                load_word   = hold_q;
                hold_full_d = 1'b0;
            end
            miso_d     = load_word[DATA_WIDTH-1];
            tx_shift_d = load_word << 1;
`ifdef SIMPLE_SPI_SLAVE_STATUS_EN
            underrun_d = !hold_full_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            bit_cnt_q   <= '0;
            new_word_q  <= 1'b0;
            rx_done_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            miso_q      <= 1'b0;
`ifdef SIMPLE_SPI_SLAVE_STATUS_EN
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            bit_cnt_q   <= bit_cnt_d;
            new_word_q  <= new_word_d;
            rx_done_q   <= rx_done_d;
            rx_valid_q  <= rx_valid_d;
            miso_q      <= miso_d;
`ifdef SIMPLE_SPI_SLAVE_STATUS_EN
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
`endif
        end
    end

    assign tx_ready = !hold_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign spi_miso = miso_q;
`ifdef SIMPLE_SPI_SLAVE_STATUS_EN
    assign tx_underrun = underrun_q;
    assign rx_abort    = abort_q;
`endif

endmodule

// File: tb/tb_simple_spi_slave.sv
// tb/tb_simple_spi_slave.sv - bench acting as SPI master with scoreboard for rx words and MISO words
module tb_simple_spi_slave;

    localparam logic [7:0] DEF_TX = 8'h5A;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       spi_clk, spi_cs_n, spi_mosi, spi_miso;
`ifdef SIMPLE_SPI_SLAVE_STATUS_EN
    logic       tx_underrun, rx_abort;
`endif

    simple_spi_slave #(.DATA_WIDTH(8), .DEFAULT_TX(DEF_TX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .spi_clk    (spi_clk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
`ifdef SIMPLE_SPI_SLAVE_STATUS_EN
        ,
        .tx_underrun(tx_underrun),
        .rx_abort   (rx_abort)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int m_underrun = 0;
    int m_abort = 0;
    int d_underrun = 0;
    int d_abort = 0;

    logic [7:0] rx_exp_q[$];
    logic [7:0] hold_m[$];
    logic [7:0] last_rx_m = 8'h00;

    logic [7:0] f_mosi   [64];
    logic       f_wr_en  [64];
    logic [7:0] f_wr_val [64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: every rx_valid pulse must match the oldest expected word, 4 clk after the last SCK rise.
    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            if (rx_exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rx_unexpected: got rx_valid with data %0h expected none", rx_data);
            end else begin
                check("rx_data", rx_data, rx_exp_q.pop_front());
                check("rx_latency", cyc - last_rise_cyc, 4);
            end
        end
`ifdef SIMPLE_SPI_SLAVE_STATUS_EN
        if (rst_n && tx_underrun) d_underrun++;
        if (rst_n && rx_abort) d_abort++;
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [7:0] load_model();
        if (hold_m.size() != 0) return hold_m.pop_front();
        m_underrun++;
        return DEF_TX;
    endfunction

    task automatic write_hold(input logic [7:0] v);
        check("tx_ready_before_write", tx_ready, 1);
        tx_data  = v;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        hold_m.push_back(v);
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_miso", spi_miso, 0);
        spi_clk  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        hold_m.delete();
        last_rx_m = 8'h00;
    endtask

    // One CS frame of nw words at SCK = clk/(2h); MISO is sampled at the end of each high phase.
    task automatic run_frame(input int nw, input int h, input int abort_after, input int rst_bit);
        logic [7:0] exp_tx, exp_next, got;
        int  rises;
        bit  stop;
        rises    = 0;
        stop     = 1'b0;
        exp_next = '0;
        exp_tx   = load_model();
        spi_cs_n = 1'b0;
        spi_mosi = f_mosi[0][7];
        ticks(2 * h);
        for (int k = 0; k < nw && !stop; k++) begin
            got = '0;
            for (int b = 0; b < 8 && !stop; b++) begin
                if (rises == abort_after) begin
                    stop = 1'b1;
                    if (rises % 8 != 0) m_abort++;
                end else if (b == rst_bit) begin
                    spi_clk = 1'b1;
                    tick();
                    mid_reset();
                    stop = 1'b1;
                end else begin
                    if (b == 7) begin
                        rx_exp_q.push_back(f_mosi[k]);
                        last_rx_m = f_mosi[k];
                    end
                    spi_clk = 1'b1;
                    rises++;
                    if (b == 7) last_rise_cyc = cyc;
                    for (int i = 0; i < h; i++) begin
                        if (i == h - 1 && b == 0 && f_wr_en[k]) write_hold(f_wr_val[k]);
                        else tick();
                    end
                    got     = {got[6:0], spi_miso};
                    spi_clk = 1'b0;
                    if (b == 7) begin
                        exp_next = load_model();
                        spi_mosi = f_mosi[k + 1][7];
                    end else begin
                        spi_mosi = f_mosi[k][6 - b];
                    end
                    ticks(h);
                end
            end
            if (!stop) begin
                check("miso_word", got, exp_tx);
                exp_tx = exp_next;
            end
        end
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        ticks(2 * h + 6);
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 64; i++) begin
            f_mosi[i]   = '0;
            f_wr_en[i]  = 1'b0;
            f_wr_val[i] = '0;
        end
    endtask

    initial begin
        int words;
        int nw;
        rst_n    = 1'b0;
        spi_clk  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        clear_frame();
        ticks(3);
        rst_n = 1'b1;
        tick();
        check("reset_tx_ready", tx_ready, 1);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_miso", spi_miso, 0);

        // Preloaded hold, SCK = clk/8.
        write_hold(8'hA5);
        f_mosi[0] = 8'h3C;
        run_frame(1, 4, -1, -1);
        check("t1_tx_ready", tx_ready, 1);
        check("t1_rx_data", rx_data, 8'h3C);

        // Empty hold returns DEFAULT_TX.
        clear_frame();
        f_mosi[0] = 8'hFF;
        run_frame(1, 4, -1, -1);
        check("t2_rx_data", rx_data, 8'hFF);

        // Back-to-back words, hold refilled with 0x12 after the first word is consumed.
        clear_frame();
        write_hold(8'hC3);
        f_mosi[0]   = 8'h81;
        f_mosi[1]   = 8'h7E;
        f_wr_en[0]  = 1'b1;
        f_wr_val[0] = 8'h12;
        run_frame(2, 4, -1, -1);

        // CS released after 3 SCK rises, then a clean frame.
        clear_frame();
        f_mosi[0] = 8'($urandom);
        run_frame(1, 4, 3, -1);
        check("abort_rx_hold", rx_data, last_rx_m);
        clear_frame();
        f_mosi[0] = 8'h96;
        run_frame(1, 4, -1, -1);

        // Reset during bit 5, then a clean frame.
        clear_frame();
        f_mosi[0] = 8'($urandom);
        run_frame(1, 4, -1, 5);
        clear_frame();
        f_mosi[0] = 8'hC7;
        write_hold(8'h3B);
        run_frame(1, 4, -1, -1);

        // Random traffic at SCK = clk/4.
        words = 0;
        while (words < 1000) begin
            clear_frame();
            nw = $urandom_range(1, 8);
            for (int k = 0; k < nw; k++) begin
                f_mosi[k]   = 8'($urandom);
                f_wr_en[k]  = 1'($urandom_range(0, 1));
                f_wr_val[k] = 8'($urandom);
            end
            if ($urandom_range(0, 1) == 1) write_hold(8'($urandom));
            run_frame(nw, 2, -1, -1);
            words += nw;
        end

        ticks(10);
        check("rx_pending", rx_exp_q.size(), 0);
`ifdef SIMPLE_SPI_SLAVE_STATUS_EN
        check("underrun_count", d_underrun, m_underrun);
        check("abort_count", d_abort, m_abort);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
